// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter that shares one main memory between the instruction and data caches.
// Each cache keeps its READ/WRITE/BUSY_WAIT handshake; one block transaction is in flight at a time.
//   state | meaning
//   IDLE  | waiting for a cache request; grant and latch on the edge
//   ISSUE | strobe held one cycle before memory busy is trusted
//   WAIT  | waiting for memory busy to drop
//   DONE  | owner's busy released for one cycle
module main_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [LINE_WIDTH-1:0] D_WRITE_DATA,
  output logic [LINE_WIDTH-1:0] D_READ_DATA,
  output logic                  D_BUSY_WAIT,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [LINE_WIDTH-1:0] I_READ_DATA,
  output logic                  I_BUSY_WAIT,
  output logic                  M_READ,
  output logic                  M_WRITE,
  output logic [ADDR_WIDTH-1:0] M_ADDRESS,
  output logic [LINE_WIDTH-1:0] M_WRITE_DATA,
  input  logic [LINE_WIDTH-1:0] M_READ_DATA,
  input  logic                  M_BUSY_WAIT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  state_t state, next_state;
  logic   owner;
  logic   last_grant;
  logic   d_req;
  logic   i_req;
  logic   grant_i;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    d_req      = D_READ | D_WRITE;
    i_req      = I_READ;
    // the instruction cache wins a tie only when the data cache was served last
    grant_i    = i_req & (~d_req | (last_grant == OWN_D));
    case (state)
      IDLE:    if (d_req | i_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (!M_BUSY_WAIT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner        <= OWN_D;
      last_grant   <= OWN_I;
      M_READ       <= 1'b0;
      M_WRITE      <= 1'b0;
      M_ADDRESS    <= '0;
      M_WRITE_DATA <= '0;
      D_READ_DATA  <= '0;
      I_READ_DATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            owner     <= OWN_I;
            M_READ    <= 1'b1;
            M_WRITE   <= 1'b0;
            M_ADDRESS <= I_ADDRESS;
          end else if (d_req) begin
            // write-back takes priority; a concurrent read is picked up as a later request
            owner        <= OWN_D;
            M_READ       <= ~D_WRITE;
            M_WRITE      <= D_WRITE;
            M_ADDRESS    <= D_ADDRESS;
            M_WRITE_DATA <= D_WRITE_DATA;
          end
        end
        WAIT: begin
          if (!M_BUSY_WAIT) begin
            if (M_READ) begin
              if (owner == OWN_I) I_READ_DATA <= M_READ_DATA;
              else                D_READ_DATA <= M_READ_DATA;
            end
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
          end
        end
        DONE:    last_grant <= owner;
        default: ;
      endcase
    end
  end

  assign D_BUSY_WAIT = (D_READ | D_WRITE) & ~((state == DONE) & (owner == OWN_D));
  assign I_BUSY_WAIT = I_READ & ~((state == DONE) & (owner == OWN_I));

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Two-port responder for the cache-to-main-memory interface: it accepts 128-bit block requests from the instruction cache and the data cache and issues them, one at a time, to a single shared main memory. It replaces the two private cache-memory links so both caches share one unified `data_memory`-style backing store. It answers each cache with the same READ/WRITE/BUSY_WAIT handshake the caches already use.

## Interface
- `ADDR_WIDTH`, 28, block address width (byte address >> 4)
- `LINE_WIDTH`, 128, cache line width in bits
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: asynchronous, active-low.
- `D_READ` input 1: data-cache block read request.
- `D_WRITE` input 1: data-cache block write-back request.
- `D_ADDRESS` input ADDR_WIDTH: data-cache block address.
- `D_WRITE_DATA` input LINE_WIDTH: data-cache write-back line.
- `D_READ_DATA` output LINE_WIDTH: line returned to the data cache.
- `D_BUSY_WAIT` output 1: data-cache stall.
- `I_READ` input 1: instruction-cache block read request.
- `I_ADDRESS` input ADDR_WIDTH: instruction-cache block address.
- `I_READ_DATA` output LINE_WIDTH: line returned to the instruction cache.
- `I_BUSY_WAIT` output 1: instruction-cache stall.
- `M_READ` output 1: main-memory read strobe.
- `M_WRITE` output 1: main-memory write strobe.
- `M_ADDRESS` output ADDR_WIDTH: main-memory block address.
- `M_WRITE_DATA` output LINE_WIDTH: main-memory write line.
- `M_READ_DATA` input LINE_WIDTH: main-memory read line.
- `M_BUSY_WAIT` input 1: main memory busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: on a rising edge with any request pending, latch owner, op, address and write data, then go to ISSUE. Change `M_READ`/`M_WRITE` from the next cycle.
- Arbitration when both are pending: round-robin. The requester not granted last wins. `last_grant` resets to instruction, so the data cache wins the first tie.
- Data cache with `D_READ` and `D_WRITE` both high: service WRITE. READ stays pending and is picked up in a later IDLE.
- ISSUE: exactly one cycle with `M_READ`/`M_WRITE` held. This guard covers memories that raise `M_BUSY_WAIT` after a delta/# delay. Go to WAIT unconditionally.
- WAIT: on an edge with `M_BUSY_WAIT`=0, do all of the following:
  - latch `M_READ_DATA` into the owner's read-data register (reads only);
  - clear `M_READ`/`M_WRITE`;
  - go to DONE.
- DONE: one cycle. The owner's done flag is high, so its BUSY_WAIT is low. Next edge: go to IDLE and update `last_grant`.
- Client stall, combinational:
  - `D_BUSY_WAIT` = (`D_READ`|`D_WRITE`) & ~(DONE & owner==D).
  - `I_BUSY_WAIT` = `I_READ` & ~(DONE & owner==I).
- A non-owner with a pending request stays stalled throughout.
- `M_ADDRESS` and `M_WRITE_DATA` come from the latched copies. Client input changes after grant do not affect the memory transaction.
- `D_READ_DATA` and `I_READ_DATA` hold their value until that client's next read completes. Writes do not alter them.

## Timing
- Reset values:
  - state IDLE;
  - `M_READ`, `M_WRITE` = 0;
  - `M_ADDRESS` and `M_WRITE_DATA` = 0;
  - `D_READ_DATA` and `I_READ_DATA` = 0;
  - owner D;
  - `last_grant` I.
- BUSY_WAIT outputs follow the combinational equations above.
- Reset mid-transaction: everything clears immediately. The strobes drop without waiting for a clock. The interrupted transaction is lost and is not retried.
- Latency, request seen at edge E0:
  - E0: grant, state ISSUE.
  - E1: state WAIT.
  - Completion edge Ec: the first edge at or after E2 with `M_BUSY_WAIT`=0.
  - BUSY_WAIT low for the cycle after Ec.
  - Minimum 3 cycles from request to the BUSY_WAIT-low cycle.
- Back-to-back: after DONE→IDLE, the pending other requester is granted at the IDLE edge. Minimum one idle-state cycle between transactions.
- The caches must drop their request on the edge that ends DONE. A request still high in IDLE is treated as a new transaction.
- `M_READ` and `M_WRITE` are never high together.

## Test plan
- **Single I read.** `I_READ`=1, `I_ADDRESS`=28'h0000004, memory 5-cycle latency returning 128'hDEAD…BEEF.
  - `M_READ` high with `M_ADDRESS`=4 for exactly the ISSUE+WAIT cycles.
  - `I_READ_DATA`=DEAD…BEEF.
  - `I_BUSY_WAIT` low for 1 cycle.
  - `D_READ_DATA` unchanged.
- **Simultaneous first requests.** `D_READ` @8 and `I_READ` @20 asserted on the same edge.
  - Data served first (`M_ADDRESS`=8), then instruction (`M_ADDRESS`=20).
  - `I_BUSY_WAIT` stays high throughout the data transaction.
- **Round-robin.** Both caches re-request continuously for 4 transactions.
  - Grant order is D, I, D, I.
  - No client is served twice in a row while the other is pending.
- **Write-back then fetch.** `D_WRITE` with data 128'h1111…, address 3, then `D_READ` address 3.
  - `M_WRITE` precedes `M_READ`.
  - Read returns 128'h1111….
  - `M_READ` & `M_WRITE` never both high.
- **Address stability.** Change `D_ADDRESS` from 6 to 9 during WAIT.
  - `M_ADDRESS` stays 6 until completion.
- **Reset mid-WAIT.** Drive `RESET` low during WAIT.
  - `M_READ`=0 before the next edge, and all read data = 0.
  - After `RESET` is released, a pending `I_READ` is granted on the first edge.
